dual_rail_sync_rx: RTL and testbench

- Receiving end of the dual-rail link produced by the async function blocks (adders, etc.) and by `dual_rail_driver`.
- Synchronizes a WIDTH-bit dual-rail token into the clock domain and detects completion.
- Presents the decoded binary word on a valid/ready interface.
- Returns the link acknowledge to the async sender.
- Supports two-phase (TP, transition) and four-phase (FP, return-to-zero) encodings. This lets synchronous checkers and consumers sit on async pipeline outputs.

---
 rtl/dual_rail_sync_rx.sv | 187 ++++++++++++++++++
 tb/tb_dual_rail_sync_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_rail_sync_rx.sv
// dual_rail_sync_rx
//
// Receives a WIDTH-bit dual-rail token from an asynchronous sender and
// synchronizes it into the clk domain. It detects when every bit has
// arrived and presents the decoded word on a valid/ready interface. It
// then returns the link acknowledge to the sender.
//
// The link encoding is selected by ENC:
//   "TP" : two-phase (transition) signalling, ack toggles once per token
//   "FP" : four-phase return-to-zero, ack rises on accept, falls on spacer
//
// Ports:
//   clk       single clock
//   rst       asynchronous reset, active low
//   in        dual-rail link, per bit rail[1] encodes 1 and rail[0] encodes 0
//   ack       registered link acknowledge back to the sender
//   data_out  decoded word, valid while valid is high
//   valid     data_out holds a complete token
//   ready     consumer accepts data_out
//   err       sticky protocol error, cleared only by reset

module dual_rail_sync_rx #(
    parameter string ENC         = "TP",
    parameter int    WIDTH       = 2,
    parameter int    RAIL_NUM    = 2,
    parameter int    SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0] in,
    output logic                           ack,
    output logic [WIDTH-1:0]               data_out,
    output logic                           valid,
    input  logic                           ready,
    output logic                           err
);

    localparam bit IsTp = (ENC == "TP");

    // Reject parameter combinations the decode logic cannot support.
    generate
        if (RAIL_NUM != 2) begin : gRailCheck
            $error("dual_rail_sync_rx: RAIL_NUM must be 2");
        end
        if (SYNC_STAGES < 2) begin : gStageCheck
            $error("dual_rail_sync_rx: SYNC_STAGES must be at least 2");
        end
        if (ENC != "TP" && ENC != "FP") begin : gEncCheck
            $error("dual_rail_sync_rx: ENC must be \"TP\" or \"FP\"");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, HOLD, RTZ, ERR} rxState_t;

    logic [WIDTH-1:0][RAIL_NUM-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0][RAIL_NUM-1:0] syncRails;
    logic [WIDTH-1:0][RAIL_NUM-1:0] ref_q, ref_d;
    rxState_t                       state_q, state_d;
    logic                           ack_q, ack_d;
    logic                           valid_q, valid_d;
    logic                           err_q, err_d;
    logic [WIDTH-1:0]               data_q, data_d;
    logic [WIDTH-1:0]               bitDone, bitErr, bitSpacer, bitValue;
    logic [RAIL_NUM-1:0]            railCode;
    logic                           wordComplete, anyBitErr, allSpacer;

    // Every rail gets its own flop chain. Each rail moves monotonically at
    // most once per token phase, so a rail that is caught late only delays
    // completion. It can never produce a wrong word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign syncRails = sync_q[SYNC_STAGES-1];

    // Per-bit decode. In TP the information is carried by which rail has
    // toggled since the last accepted token, so the rails are compared
    // against ref_q. In FP the rail levels are decoded directly.
    always_comb begin
        bitDone   = '0;
        bitErr    = '0;
        bitSpacer = '0;
        bitValue  = '0;
        railCode  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            railCode     = IsTp ? (syncRails[i] ^ ref_q[i]) : syncRails[i];
            bitDone[i]   = (railCode == 2'b01) || (railCode == 2'b10);
            bitErr[i]    = (railCode == 2'b11);
            bitValue[i]  = railCode[1];
            bitSpacer[i] = (syncRails[i] == 2'b00);
        end
    end

    assign wordComplete = &bitDone;
    assign anyBitErr    = |bitErr;
    assign allSpacer    = &bitSpacer;

    // State and output registers. The acknowledge is registered, so the
    // sender only ever sees a glitch-free ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ref_q   <= '0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    // Handshake FSM. A rail error has priority over every other transition
    // and locks the receiver in ERR with ack frozen. Reset is the only way
    // out, because the sender has to be reset alongside it.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        ack_d   = ack_q;
        valid_d = valid_q;
        err_d   = err_q;
        data_d  = data_q;
        if (state_q != ERR && anyBitErr) begin
            state_d = ERR;
            valid_d = 1'b0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wordComplete) begin
                        data_d  = bitValue;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        valid_d = 1'b0;
                        if (IsTp) begin
                            ref_d   = syncRails;
                            ack_d   = ~ack_q;
                            state_d = IDLE;
                        end else begin
                            ack_d   = 1'b1;
                            state_d = RTZ;
                        end
                    end
                end
                RTZ: begin
                    if (allSpacer) begin
                        ack_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                ERR: begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                end
                default: begin
                    state_d = ERR;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign data_out = data_q;

endmodule

// File: tb/tb_dual_rail_sync_rx.sv
// Bench for dual_rail_sync_rx. It runs one two-phase and one four-phase
// instance side by side. The bench keeps the sender's rail state and an
// expected-ack token count, and derives every expected value from them.
module tb_dual_rail_sync_rx;

    localparam int W      = 2;
    localparam int STAGES = 2;
    localparam int LAT    = STAGES + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [W-1:0][1:0] inTp, inFp;
    logic              readyTp, readyFp;
    logic              ackTp, validTp, errTp;
    logic              ackFp, validFp, errFp;
    logic [W-1:0]      dataTp, dataFp;

    int                checks   = 0;
    int                failures = 0;

    // Sender-side model: the current rail levels and the ack level each
    // sender expects after the tokens accepted so far.
    logic [W-1:0][1:0] tpRails, fpRails;
    logic              tpAckExp, fpAckExp;

    always #5 clk = ~clk;

    dual_rail_sync_rx #(.ENC("TP"), .WIDTH(W), .RAIL_NUM(2), .SYNC_STAGES(STAGES)) dutTp (
        .clk(clk), .rst(rst), .in(inTp), .ack(ackTp), .data_out(dataTp),
        .valid(validTp), .ready(readyTp), .err(errTp)
    );

    dual_rail_sync_rx #(.ENC("FP"), .WIDTH(W), .RAIL_NUM(2), .SYNC_STAGES(STAGES)) dutFp (
        .clk(clk), .rst(rst), .in(inFp), .ack(ackFp), .data_out(dataFp),
        .valid(validFp), .ready(readyFp), .err(errFp)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0][1:0] tp, input logic [W-1:0][1:0] fp);
        inTp = tp;
        inFp = fp;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A two-phase sender toggles the rail that matches each bit's value.
    task automatic tpSendBits(input logic [W-1:0] word, input logic [W-1:0] mask);
        for (int i = 0; i < W; i++) begin
            if (mask[i]) tpRails[i][word[i]] = ~tpRails[i][word[i]];
        end
        applyStimulus(tpRails, fpRails);
    endtask

    // The last bit has just been driven with ready low. Expect valid after
    // LAT clocks, a stable hold, and then an ack toggle on accept.
    task automatic tpExpectToken(input logic [W-1:0] word, input int hold);
        step(LAT - 1);
        checkOutput("tp_valid_early", validTp, 0);
        step(1);
        checkOutput("tp_valid_rise", validTp, 1);
        checkOutput("tp_data", dataTp, word);
        repeat (hold) begin
            step(1);
            checkOutput("tp_hold_valid", validTp, 1);
            checkOutput("tp_hold_data", dataTp, word);
            checkOutput("tp_hold_ack", ackTp, tpAckExp);
        end
        readyTp = 1'b1;
        step(1);
        tpAckExp = ~tpAckExp;
        checkOutput("tp_accept_valid", validTp, 0);
        checkOutput("tp_accept_ack", ackTp, tpAckExp);
        readyTp = 1'b0;
    endtask

    // A four-phase token: raise one rail per bit (staggered), accept, then
    // return to spacer and expect ack to fall LAT clocks later.
    task automatic fpToken(input logic [W-1:0] word, input int hold);
        for (int i = 0; i < W; i++) begin
            if (i > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    step(1);
                    checkOutput("fp_partial_valid", validFp, 0);
                end
            end
            fpRails[i] = word[i] ? 2'b10 : 2'b01;
            applyStimulus(tpRails, fpRails);
        end
        step(LAT - 1);
        checkOutput("fp_valid_early", validFp, 0);
        step(1);
        checkOutput("fp_valid_rise", validFp, 1);
        checkOutput("fp_data", dataFp, word);
        repeat (hold) begin
            step(1);
            checkOutput("fp_hold_data", dataFp, word);
            checkOutput("fp_hold_ack", ackFp, 0);
        end
        readyFp = 1'b1;
        step(1);
        readyFp = 1'b0;
        checkOutput("fp_accept_valid", validFp, 0);
        checkOutput("fp_accept_ack", ackFp, 1);
        repeat ($urandom_range(0, 3)) begin
            step(1);
            checkOutput("fp_ack_held", ackFp, 1);
        end
        fpRails = '0;
        applyStimulus(tpRails, fpRails);
        step(LAT - 1);
        checkOutput("fp_ack_before_rtz", ackFp, 1);
        step(1);
        checkOutput("fp_ack_rtz", ackFp, 0);
    endtask

    initial begin
        logic [W-1:0] word;
        logic         sawValid;

        rst      = 1'b0;
        readyTp  = 1'b0;
        readyFp  = 1'b0;
        tpRails  = '0;
        fpRails  = '0;
        tpAckExp = 1'b0;
        fpAckExp = 1'b0;
        applyStimulus(tpRails, fpRails);

        // Reset held with the inputs toggling: every output stays at zero.
        repeat (6) begin
            applyStimulus(W'($urandom) ^ {W{2'b11}}, 4'($urandom));
            step(1);
            checkOutput("rst_tp_outs", {validTp, ackTp, errTp, dataTp}, 0);
            checkOutput("rst_fp_outs", {validFp, ackFp, errFp, dataFp}, 0);
        end
        applyStimulus(tpRails, fpRails);
        step(LAT);
        rst = 1'b1;
        step(4);
        checkOutput("post_rst_tp", {validTp, ackTp, errTp, dataTp}, 0);
        checkOutput("post_rst_fp", {validFp, ackFp, errFp, dataFp}, 0);

        // TP with ready held high: valid is high for exactly one clock.
        readyTp = 1'b1;
        tpSendBits(2'b01, 2'b11);
        step(LAT - 1);
        checkOutput("tp_r1_early", validTp, 0);
        step(1);
        checkOutput("tp_r1_valid", validTp, 1);
        checkOutput("tp_r1_data", dataTp, 2'b01);
        checkOutput("tp_r1_ack_before", ackTp, 0);
        step(1);
        checkOutput("tp_r1_valid_drop", validTp, 0);
        checkOutput("tp_r1_ack", ackTp, 1);
        tpSendBits(2'b10, 2'b11);
        step(LAT);
        checkOutput("tp_r1b_valid", validTp, 1);
        checkOutput("tp_r1b_data", dataTp, 2'b10);
        step(1);
        checkOutput("tp_r1b_valid_drop", validTp, 0);
        checkOutput("tp_r1b_ack", ackTp, 0);
        readyTp = 1'b0;

        // Backpressure: the token is held for 10 clocks.
        tpSendBits(2'b11, 2'b11);
        tpExpectToken(2'b11, 10);

        // Partial token: only bit0 arrives, so nothing happens.
        word = W'($urandom);
        tpSendBits(word, 2'b01);
        sawValid = 1'b0;
        repeat (20) begin
            step(1);
            if (validTp) sawValid = 1'b1;
        end
        checkOutput("tp_partial_wait", sawValid, 0);
        tpSendBits(word, 2'b10);
        tpExpectToken(word, 0);

        // Randomized TP tokens with staggered bit arrival and random hold.
        for (int t = 0; t < 20; t++) begin
            word = W'($urandom);
            for (int i = 0; i < W; i++) begin
                if (i > 0) begin
                    repeat ($urandom_range(0, 2)) begin
                        step(1);
                        checkOutput("tp_partial_valid", validTp, 0);
                    end
                end
                tpSendBits(word, W'(1) << i);
            end
            tpExpectToken(word, $urandom_range(0, 3));
        end

        // FP directed: word 2'b10 with ready high, then spacer.
        readyFp = 1'b1;
        fpRails = {2'b10, 2'b01};
        applyStimulus(tpRails, fpRails);
        step(LAT - 1);
        checkOutput("fp_d_early", validFp, 0);
        step(1);
        checkOutput("fp_d_valid", validFp, 1);
        checkOutput("fp_d_data", dataFp, 2'b10);
        step(1);
        checkOutput("fp_d_valid_drop", validFp, 0);
        checkOutput("fp_d_ack", ackFp, 1);
        readyFp = 1'b0;
        repeat (5) begin
            step(1);
            checkOutput("fp_d_ack_held", ackFp, 1);
        end
        fpRails = '0;
        applyStimulus(tpRails, fpRails);
        step(LAT - 1);
        checkOutput("fp_d_ack_pre", ackFp, 1);
        step(1);
        checkOutput("fp_d_ack_rtz", ackFp, 0);

        // Randomized FP tokens.
        for (int t = 0; t < 10; t++) begin
            fpToken(W'($urandom), $urandom_range(0, 3));
        end
        checkOutput("fp_err_clear", errFp, 0);

        // TP rail error: both rails of bit0 toggle together.
        tpRails[0] = tpRails[0] ^ 2'b11;
        applyStimulus(tpRails, fpRails);
        step(LAT + 1);
        checkOutput("err_set", errTp, 1);
        checkOutput("err_valid", validTp, 0);
        checkOutput("err_ack_frozen", ackTp, tpAckExp);
        readyTp = 1'b1;
        tpSendBits(W'($urandom), 2'b11);
        sawValid = 1'b0;
        repeat (10) begin
            step(1);
            if (validTp) sawValid = 1'b1;
        end
        checkOutput("err_ignores_tokens", sawValid, 0);
        checkOutput("err_sticky", errTp, 1);
        checkOutput("err_ack_still", ackTp, tpAckExp);
        readyTp = 1'b0;

        // Asynchronous reset clears the error without waiting for a clock.
        rst = 1'b0;
        #1;
        checkOutput("err_rst_clear", errTp, 0);
        checkOutput("err_rst_ack", ackTp, 0);
        tpRails  = '0;
        fpRails  = '0;
        tpAckExp = 1'b0;
        applyStimulus(tpRails, fpRails);
        step(LAT);
        rst = 1'b1;
        step(2);
        tpSendBits(2'b10, 2'b11);
        tpExpectToken(2'b10, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
